// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer:
// state encoding, output widths, defaults and a counter-width helper.
package pll_reset_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_HOLD      = 2'd1;
    localparam state_t ST_RELEASE   = 2'd2;
    localparam state_t ST_RUN       = 2'd3;

    localparam int LOSS_COUNT_W = 8;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_LOCK_HOLD    = 1024;
    localparam int DEF_RESET_CYCLES = 16;
    localparam int DEF_CE_DIV       = 4;
    localparam int DEF_LOCK_TIMEOUT = 65535;

    // Counter width for a terminal count of n, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Generic N-stage single-bit synchroniser with async active-low reset.
// Also used for push-button inputs.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock into a synchronously released system reset and a CPU
// clock-enable; re-enters reset on lock loss and counts those losses.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int LOCK_HOLD    = DEF_LOCK_HOLD,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int CE_DIV       = DEF_CE_DIV,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    pll_locked,
    output logic                    sys_resetn,
    output logic                    cpu_ce,
    output logic                    ready,
    output logic                    lock_timeout,
    output logic [LOSS_COUNT_W-1:0] loss_count
);

    localparam int HOLD_W = cnt_w(LOCK_HOLD);
    localparam int REL_W  = cnt_w(RESET_CYCLES);
    localparam int CNT_W  = (HOLD_W > REL_W) ? HOLD_W : REL_W;
    localparam int TO_W   = cnt_w(LOCK_TIMEOUT);
    localparam int DIV_W  = cnt_w(CE_DIV);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [DIV_W-1:0] CE_LAST   = DIV_W'(CE_DIV - 1);

    logic                    w_lock_s;
    logic [DIV_W-1:0]        w_div_nxt;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [TO_W-1:0]         r_to_cnt;
    logic [DIV_W-1:0]        r_div;
    logic                    r_sys_resetn;
    logic                    r_ce;
    logic                    r_ready;
    logic                    r_timeout;
    logic [LOSS_COUNT_W-1:0] r_loss;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    // Next CE divider value; wraps after the enable cycle.
    always_comb begin
        w_div_nxt = r_div + DIV_W'(1);
        if (r_div == CE_LAST) begin
            w_div_nxt = '0;
        end
    end

    // Sequencer FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_div        <= '0;
            r_sys_resetn <= 1'b0;
            r_ce         <= 1'b0;
            r_ready      <= 1'b0;
            r_timeout    <= 1'b0;
            r_loss       <= '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_to_cnt <= '0;
                    end else if (!r_timeout) begin
                        if (r_to_cnt == TO_LAST) begin
                            r_timeout <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == REL_LAST) begin
                        r_state      <= ST_RUN;
                        r_cnt        <= '0;
                        r_div        <= '0;
                        r_sys_resetn <= 1'b1;
                        r_ready      <= 1'b1;
                        r_ce         <= (CE_DIV == 1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state      <= ST_WAIT_LOCK;
                        r_div        <= '0;
                        r_sys_resetn <= 1'b0;
                        r_ready      <= 1'b0;
                        r_ce         <= 1'b0;
                        if (r_loss != '1) begin
                            r_loss <= r_loss + LOSS_COUNT_W'(1);
                        end
                    end else begin
                        r_div <= w_div_nxt;
                        r_ce  <= (w_div_nxt == CE_LAST);
                    end
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign sys_resetn   = r_sys_resetn;
    assign cpu_ce       = r_ce;
    assign ready        = r_ready;
    assign lock_timeout = r_timeout;
    assign loss_count   = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// With SYNC_STAGES=2, LOCK_HOLD=8, RESET_CYCLES=4 sys_resetn rises on the
// 15th edge counting the first edge that samples pll_locked high.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       sys_resetn;
    logic       cpu_ce;
    logic       ready;
    logic       lock_timeout;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES  (2),
        .LOCK_HOLD    (8),
        .RESET_CYCLES (4),
        .CE_DIV       (4),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .sys_resetn   (sys_resetn),
        .cpu_ce       (cpu_ce),
        .ready        (ready),
        .lock_timeout (lock_timeout),
        .loss_count   (loss_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        pll_locked = 1'b0;
        repeat (5) tick();
        checks++;
        if (sys_resetn !== 1'b0) begin
            errors++; $display("FAIL rst_sys_resetn got %b want 0", sys_resetn);
        end
        checks++;
        if (cpu_ce !== 1'b0) begin
            errors++; $display("FAIL rst_cpu_ce got %b want 0", cpu_ce);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready got %b want 0", ready);
        end
        checks++;
        if (lock_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_timeout got %b want 0", lock_timeout);
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++; $display("FAIL rst_loss got %0d want 0", loss_count);
        end
        resetn = 1'b1;
        repeat (5) tick();
        checks++;
        if (sys_resetn !== 1'b0) begin
            errors++; $display("FAIL nolock_sys_resetn got %b want 0", sys_resetn);
        end
    endtask

    task automatic test_power_up();
        logic exp;
        pll_locked = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp = (k == 15);
            checks++;
            if (sys_resetn !== exp) begin
                errors++;
                $display("FAIL pu_sys_resetn edge %0d got %b want %b", k, sys_resetn, exp);
            end
            checks++;
            if (ready !== exp) begin
                errors++;
                $display("FAIL pu_ready edge %0d got %b want %b", k, ready, exp);
            end
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = ((j % 4) == 3);
            checks++;
            if (cpu_ce !== exp) begin
                errors++;
                $display("FAIL pu_cpu_ce tick %0d got %b want %b", j, cpu_ce, exp);
            end
        end
        checks++;
        if (lock_timeout !== 1'b0) begin
            errors++; $display("FAIL pu_timeout got %b want 0", lock_timeout);
        end
    endtask

    task automatic test_lock_loss_run();
        logic exp;
        pll_locked = 1'b0;
        tick();
        tick();
        checks++;
        if (sys_resetn !== 1'b1) begin
            errors++; $display("FAIL loss_early got %b want 1", sys_resetn);
        end
        tick();
        checks++;
        if (sys_resetn !== 1'b0) begin
            errors++; $display("FAIL loss_sys_resetn got %b want 0", sys_resetn);
        end
        checks++;
        if (cpu_ce !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL loss_ce_ready got %b/%b want 0/0", cpu_ce, ready);
        end
        checks++;
        if (loss_count !== 8'd1) begin
            errors++; $display("FAIL loss_count got %0d want 1", loss_count);
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp = (k == 15);
            checks++;
            if (sys_resetn !== exp) begin
                errors++;
                $display("FAIL relock edge %0d got %b want %b", k, sys_resetn, exp);
            end
        end
        checks++;
        if (loss_count !== 8'd1) begin
            errors++; $display("FAIL relock_loss got %0d want 1", loss_count);
        end
    endtask

    task automatic test_saturation();
        int exp_loss = 1;
        int n;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            n = 0;
            while (ready !== 1'b0 && n < 10) begin
                tick(); n++;
            end
            if (ready !== 1'b0) begin
                checks++; errors++;
                $display("FAIL sat_drop_wait iter %0d ready %b want 0", i, ready);
            end
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            checks++;
            if (loss_count !== exp_loss[7:0]) begin
                errors++;
                $display("FAIL sat_loss iter %0d got %0d want %0d", i, loss_count, exp_loss);
            end
            pll_locked = 1'b1;
            n = 0;
            while (ready !== 1'b1 && n < 30) begin
                tick(); n++;
            end
            if (ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL sat_relock_wait iter %0d ready %b want 1", i, ready);
            end
        end
        checks++;
        if (loss_count !== 8'd255) begin
            errors++; $display("FAIL sat_final got %0d want 255", loss_count);
        end
    endtask

    task automatic test_hold_glitch();
        logic exp;
        resetn     = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            tick();
            exp = (k == 16);
            checks++;
            if (sys_resetn !== exp) begin
                errors++;
                $display("FAIL glitch edge %0d got %b want %b", k, sys_resetn, exp);
            end
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++; $display("FAIL glitch_loss got %0d want 0", loss_count);
        end
    endtask

    task automatic test_timeout();
        logic exp;
        resetn     = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k >= 99) begin
                exp = (k == 100);
                checks++;
                if (lock_timeout !== exp) begin
                    errors++;
                    $display("FAIL to_flag edge %0d got %b want %b", k, lock_timeout, exp);
                end
            end
        end
        repeat (20) tick();
        checks++;
        if (lock_timeout !== 1'b1) begin
            errors++; $display("FAIL to_sticky got %b want 1", lock_timeout);
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp = (k == 15);
            checks++;
            if (sys_resetn !== exp) begin
                errors++;
                $display("FAIL to_lock edge %0d got %b want %b", k, sys_resetn, exp);
            end
        end
        checks++;
        if (lock_timeout !== 1'b1) begin
            errors++; $display("FAIL to_after_run got %b want 1", lock_timeout);
        end
    endtask

    task automatic test_async_reset();
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (ready !== 1'b0 && n < 10) begin
            tick(); n++;
        end
        pll_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 30) begin
            tick(); n++;
        end
        checks++;
        if (loss_count !== 8'd1 || lock_timeout !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre loss %0d to %b want 1/1", loss_count, lock_timeout);
        end
        n = 0;
        while (cpu_ce !== 1'b1 && n < 8) begin
            tick(); n++;
        end
        checks++;
        if (cpu_ce !== 1'b1 || sys_resetn !== 1'b1) begin
            errors++;
            $display("FAIL ar_run ce %b sys %b want 1/1", cpu_ce, sys_resetn);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (sys_resetn !== 1'b0 || ready !== 1'b0 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL ar_outs sys %b rdy %b ce %b want 0", sys_resetn, ready, cpu_ce);
        end
        checks++;
        if (loss_count !== 8'd0) begin
            errors++; $display("FAIL ar_loss got %0d want 0", loss_count);
        end
        checks++;
        if (lock_timeout !== 1'b0) begin
            errors++; $display("FAIL ar_timeout got %b want 0", lock_timeout);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss_run();
        test_saturation();
        test_hold_glitch();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
